// File: rtl/alu_ctrl_seq_if.sv
// Request/beat bus joining the control unit (issue side), alu_ctrl_seq and the
// accumulator datapath (beat side).
interface alu_ctrl_seq_if #(
    parameter int OPW   = 5,
    parameter int CTRLW = 4,
    parameter int SHW   = 4
);
    logic [1:0]       ALUOp;
    logic [OPW-1:0]   Opcode;
    logic [OPW-1:0]   AlterOp;
    logic [SHW-1:0]   ShAmt;
    logic             InValid;
    logic             InReady;
    logic [CTRLW-1:0] Out;
    logic             OutValid;
    logic             OutReady;
    logic             Step;
    logic             Last;
    logic             Busy;
    logic             Illegal;

    modport master (
        output ALUOp, Opcode, AlterOp, ShAmt, InValid, OutReady,
        input  InReady, Out, OutValid, Step, Last, Busy, Illegal
    );

    modport slave (
        input  ALUOp, Opcode, AlterOp, ShAmt, InValid, OutReady,
        output InReady, Out, OutValid, Step, Last, Busy, Illegal
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder that expands multi-bit shifts into 1-bit shift beats.
// Optional sticky unmapped-code flag enabled by defining ALU_CTRL_ILLEGAL_EN.
module alu_ctrl_seq #(
    parameter int OPW   = 5,
    parameter int CTRLW = 4,
    parameter int SHW   = 4
) (
    input  logic          CLK,
    input  logic          Reset_n,
    alu_ctrl_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [3:0]     code_p1, code_nx;
    logic           step_p1, step_nx;
    logic           last_p1, last_nx;
    logic [SHW-1:0] cnt_p1, cnt_nx;
    logic           vld_p1;
    logic           in_ready;
    logic           accept;
    logic           consumed;
    logic [3:0]     dec_code;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic           dec_mapped;
    logic           illegal_p1, illegal_nx;
`endif

    // Returns {mapped, code}; any set bit above [4:0] of the selected field is unmapped.
    function automatic logic [4:0] lookup(input logic [1:0]     alu_op,
                                          input logic [OPW-1:0] opcode,
                                          input logic [OPW-1:0] alter_op);
        logic [4:0] res;
        res = 5'b0_0000;
        case (alu_op)
            2'b00: res = 5'b1_0000;
            2'b01: res = 5'b1_0001;
            2'b10: begin
                if ((opcode >> 5) == '0) begin
                    case (opcode[4:0])
                        5'b00000: res = 5'b1_0000;
                        5'b00001: res = 5'b1_0001;
                        5'b00010: res = 5'b1_0111;
                        5'b00011: res = 5'b1_0101;
                        5'b00100: res = 5'b1_0110;
                        5'b00101: res = 5'b1_0010;
                        5'b01000: res = 5'b1_0101;
                        5'b01001: res = 5'b1_0111;
                        5'b01010: res = 5'b1_0110;
                        5'b01011: res = 5'b1_0000;
                        5'b01100: res = 5'b1_0010;
                        5'b01101: res = 5'b1_0011;
                        5'b01110: res = 5'b1_0100;
                        5'b01111: res = 5'b1_1011;
                        5'b10000: res = 5'b1_1000;
                        5'b10001: res = 5'b1_1010;
                        5'b10010: res = 5'b1_1011;
                        5'b10011: res = 5'b1_1011;
                        5'b10111: res = 5'b1_0000;
                        5'b11000: res = 5'b1_1111;
                        5'b11001: res = 5'b1_0000;
                        5'b11101: res = 5'b1_1110;
                        default:  res = 5'b0_0000;
                    endcase
                end
            end
            default: begin
                if ((alter_op >> 5) == '0) begin
                    case (alter_op[4:0])
                        5'b00000: res = 5'b1_0000;
                        5'b00001: res = 5'b1_0001;
                        5'b00110: res = 5'b1_0011;
                        5'b00111: res = 5'b1_0100;
                        5'b01101: res = 5'b1_1100;
                        5'b01110: res = 5'b1_1101;
                        default:  res = 5'b0_0000;
                    endcase
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic is_shift(input logic [3:0] code);
        return (code == 4'b0011) || (code == 4'b0100);
    endfunction

    always_comb begin
        state_nx = state;
        code_nx  = code_p1;
        step_nx  = step_p1;
        last_nx  = last_p1;
        cnt_nx   = cnt_p1;
`ifdef ALU_CTRL_ILLEGAL_EN
        illegal_nx = illegal_p1;
        {dec_mapped, dec_code} = lookup(bus.ALUOp, bus.Opcode, bus.AlterOp);
`else
        dec_code = 4'(lookup(bus.ALUOp, bus.Opcode, bus.AlterOp));
`endif

        case (state)
            IDLE:    in_ready = 1'b1;
            ISSUE:   in_ready = bus.OutReady;
            default: in_ready = 1'b0;
        endcase
        consumed = vld_p1 && bus.OutReady;
        accept   = bus.InValid && in_ready;

        if (consumed) begin
            if (last_p1) begin
                state_nx = IDLE;
                code_nx  = 4'b0000;
                step_nx  = 1'b0;
                last_nx  = 1'b0;
                cnt_nx   = '0;
            end else begin
                // Only SHIFT beats are ever non-last; the next beat is last when one remains.
                cnt_nx  = cnt_p1 - SHW'(1);
                last_nx = (cnt_p1 == SHW'(2));
            end
        end

        // A request accepted alongside a consumed ISSUE beat replaces it with no bubble.
        if (accept) begin
            code_nx = dec_code;
            if (is_shift(dec_code) && (bus.ShAmt != '0)) begin
                state_nx = SHIFT;
                cnt_nx   = bus.ShAmt;
                step_nx  = 1'b1;
                last_nx  = (bus.ShAmt == SHW'(1));
            end else begin
                state_nx = ISSUE;
                cnt_nx   = '0;
                last_nx  = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_EN
                step_nx    = dec_mapped && !is_shift(dec_code);
                illegal_nx = illegal_p1 || !dec_mapped;
`else
                step_nx    = !is_shift(dec_code);
`endif
            end
        end
    end

    // Beat register stage
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state   <= IDLE;
            code_p1 <= 4'b0000;
            step_p1 <= 1'b0;
            last_p1 <= 1'b0;
            cnt_p1  <= '0;
        end else begin
            state   <= state_nx;
            code_p1 <= code_nx;
            step_p1 <= step_nx;
            last_p1 <= last_nx;
            cnt_p1  <= cnt_nx;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            illegal_p1 <= 1'b0;
        end else begin
            illegal_p1 <= illegal_nx;
        end
    end

    assign bus.Illegal = illegal_p1;
`else
    assign bus.Illegal = 1'b0;
`endif

    assign vld_p1       = (state != IDLE);
    assign bus.InReady  = in_ready;
    assign bus.Out      = CTRLW'(code_p1);
    assign bus.OutValid = vld_p1;
    assign bus.Step     = step_p1;
    assign bus.Last     = last_p1;
    assign bus.Busy     = (state == SHIFT);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus randomized traffic
// against a beat-queue reference model.
module tb_alu_ctrl_seq;
    localparam int OPW   = 5;
    localparam int CTRLW = 4;
    localparam int SHW   = 4;
    localparam int VW    = CTRLW + 6;
`ifdef ALU_CTRL_ILLEGAL_EN
    localparam bit ILLEGAL_ON = 1'b1;
`else
    localparam bit ILLEGAL_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic Reset_n;
    always #5 CLK = ~CLK;

    alu_ctrl_seq_if #(.OPW(OPW), .CTRLW(CTRLW), .SHW(SHW)) bus ();

    alu_ctrl_seq #(.OPW(OPW), .CTRLW(CTRLW), .SHW(SHW)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] code;
        logic       step;
        logic       last;
        logic       shift;
    } beat_t;

    beat_t          q[$];
    logic           illegal_m;
    logic           exp_ir;
    logic [VW-1:0]  exp_vec;
    int             opc_tab[32];
    int             alt_tab[32];
    int             checks   = 0;
    int             failures = 0;

    function automatic void init_tables();
        for (int i = 0; i < 32; i++) begin
            opc_tab[i] = -1;
            alt_tab[i] = -1;
        end
        opc_tab[0]  = 0;  opc_tab[1]  = 1;  opc_tab[2]  = 7;  opc_tab[3]  = 5;
        opc_tab[4]  = 6;  opc_tab[5]  = 2;  opc_tab[8]  = 5;  opc_tab[9]  = 7;
        opc_tab[10] = 6;  opc_tab[11] = 0;  opc_tab[12] = 2;  opc_tab[13] = 3;
        opc_tab[14] = 4;  opc_tab[15] = 11; opc_tab[16] = 8;  opc_tab[17] = 10;
        opc_tab[18] = 11; opc_tab[19] = 11; opc_tab[23] = 0;  opc_tab[24] = 15;
        opc_tab[25] = 0;  opc_tab[29] = 14;
        alt_tab[0]  = 0;  alt_tab[1]  = 1;  alt_tab[6]  = 3;  alt_tab[7]  = 4;
        alt_tab[13] = 12; alt_tab[14] = 13;
    endfunction

    // Reference: one accepted request becomes a list of beats the datapath must see.
    function automatic void push_request(input logic [1:0] op, input logic [OPW-1:0] opc,
                                         input logic [OPW-1:0] alt, input logic [SHW-1:0] sh);
        int    code;
        bit    mapped;
        beat_t b;
        case (op)
            2'd0:    code = 0;
            2'd1:    code = 1;
            2'd2:    code = (int'(opc) < 32) ? opc_tab[int'(opc)] : -1;
            default: code = (int'(alt) < 32) ? alt_tab[int'(alt)] : -1;
        endcase
        mapped = (code >= 0);
        if (!mapped) code = 0;
        b.code = 4'(code);
        if ((code == 3 || code == 4) && sh != 0) begin
            for (int i = 1; i <= int'(sh); i++) begin
                b.step = 1'b1; b.last = (i == int'(sh)); b.shift = 1'b1;
                q.push_back(b);
            end
        end else begin
            b.step  = !(code == 3 || code == 4) && (mapped || !ILLEGAL_ON);
            b.last  = 1'b1;
            b.shift = 1'b0;
            q.push_back(b);
            if (!mapped && ILLEGAL_ON) illegal_m = 1'b1;
        end
    endfunction

    function automatic logic [VW-1:0] obs();
        return {bus.OutValid, bus.Out, bus.Step, bus.Last, bus.Busy, bus.InReady, bus.Illegal};
    endfunction

    // Applies this cycle's inputs and forms the expected output vector.
    task automatic drive(input logic v, input logic [1:0] op, input logic [OPW-1:0] opc,
                         input logic [OPW-1:0] alt, input logic [SHW-1:0] sh, input logic ordy);
        bus.InValid  = v;
        bus.ALUOp    = op;
        bus.Opcode   = opc;
        bus.AlterOp  = alt;
        bus.ShAmt    = sh;
        bus.OutReady = ordy;
        #1;
        if (q.size() == 0) begin
            exp_ir  = 1'b1;
            exp_vec = {1'b0, CTRLW'(0), 1'b0, 1'b0, 1'b0, 1'b1, illegal_m};
        end else begin
            exp_ir  = q[0].shift ? 1'b0 : ordy;
            exp_vec = {1'b1, CTRLW'(q[0].code), q[0].step, q[0].last, q[0].shift, exp_ir, illegal_m};
        end
    endtask

    task automatic advance();
        if (!Reset_n) begin
            q.delete();
            illegal_m = 1'b0;
        end else begin
            if (q.size() != 0 && bus.OutReady) void'(q.pop_front());
            if (bus.InValid && exp_ir) push_request(bus.ALUOp, bus.Opcode, bus.AlterOp, bus.ShAmt);
        end
        @(negedge CLK);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 64) begin
            drive(1'b0, 2'd0, '0, '0, '0, 1'b1);
            advance();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: beats_left=%0d required=0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        drive(1'b0, 2'd0, '0, '0, '0, 1'b0);
        advance();
        drive(1'b0, 2'd0, '0, '0, '0, 1'b0);
        checks++;
        if (obs() !== exp_vec) begin
            failures++;
            $display("FAIL reset_held: got %b required %b", obs(), exp_vec);
        end
        advance();
        Reset_n = 1'b1;
        drive(1'b0, 2'd0, '0, '0, '0, 1'b1);
        checks++;
        if (obs() !== {1'b0, CTRLW'(0), 4'b0001, 1'b0}) begin
            failures++;
            $display("FAIL reset_release: got %b required %b", obs(), {1'b0, CTRLW'(0), 4'b0001, 1'b0});
        end
        advance();
    endtask

    task automatic test_opcode_single();
        drive(1'b1, 2'b10, 5'b01111, '0, '0, 1'b1);
        advance();
        drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
        checks++;
        if (obs() !== exp_vec || bus.Out !== CTRLW'(4'b1011) || bus.Step !== 1'b1 || bus.Last !== 1'b1) begin
            failures++;
            $display("FAIL opcode_01111_beat: got %b required %b (Out=1011)", obs(), exp_vec);
        end
        advance();
        drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
        checks++;
        if (obs() !== exp_vec || bus.OutValid !== 1'b0) begin
            failures++;
            $display("FAIL opcode_back_to_idle: got %b required %b", obs(), exp_vec);
        end
        advance();
    endtask

    task automatic test_shift(input bit stall);
        int hs = 0;
        drive(1'b1, 2'b11, '0, 5'b00110, 4'd3, 1'b1);
        advance();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 2'b00, '0, '0, '0, !(stall && k >= 2 && k <= 5));
            checks++;
            if (obs() !== exp_vec) begin
                failures++;
                $display("FAIL shift3_stall%0d cycle %0d: got %b required %b", stall, k, obs(), exp_vec);
            end
            if (bus.OutValid && bus.OutReady) hs++;
            advance();
        end
        checks++;
        if (hs != 3) begin
            failures++;
            $display("FAIL shift3_stall%0d_beats: got %0d required 3", stall, hs);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'b00, '0, '0, '0, 1'b1);
        advance();
        drive(1'b1, 2'b01, '0, '0, '0, 1'b1);
        checks++;
        if (obs() !== exp_vec || bus.Out !== CTRLW'(0) || bus.OutValid !== 1'b1 || bus.InReady !== 1'b1) begin
            failures++;
            $display("FAIL b2b_add: got %b required %b", obs(), exp_vec);
        end
        advance();
        drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
        checks++;
        if (obs() !== exp_vec || bus.Out !== CTRLW'(1) || bus.OutValid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_sub: got %b required %b", obs(), exp_vec);
        end
        advance();
        drain();
    endtask

    task automatic test_reset_mid_shift();
        drive(1'b1, 2'b11, '0, 5'b00110, 4'd15, 1'b1);
        advance();
        drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
        advance();
        Reset_n = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
        checks++;
        if (obs() !== exp_vec || bus.Busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_beat2: got %b required %b", obs(), exp_vec);
        end
        advance();
        Reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
            checks++;
            if (obs() !== exp_vec || bus.OutValid !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_after %0d: got %b required %b", k, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_max_shift();
        int hs = 0;
        int lasts = 0;
        drive(1'b1, 2'b10, 5'b01110, '0, 4'd15, 1'b1);
        advance();
        for (int k = 0; k < 60 && q.size() != 0; k++) begin
            drive(1'b0, 2'b00, '0, '0, '0, 1'($urandom_range(0, 3) != 0));
            checks++;
            if (obs() !== exp_vec) begin
                failures++;
                $display("FAIL maxshift cycle %0d: got %b required %b", k, obs(), exp_vec);
            end
            if (bus.OutValid && bus.OutReady) begin
                hs++;
                if (bus.Last) lasts++;
            end
            advance();
        end
        checks++;
        if (hs != 15 || lasts != 1) begin
            failures++;
            $display("FAIL maxshift_beats: got %0d beats %0d lasts required 15 and 1", hs, lasts);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 2'b10, 5'b00110, '0, '0, 1'b1);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'b00, '0, '0, '0, 1'b1);
            checks++;
            if (obs() !== exp_vec || bus.Illegal !== ILLEGAL_ON) begin
                failures++;
                $display("FAIL illegal cycle %0d: got %b required %b", k, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [1:0]     op;
        logic [OPW-1:0] opc, alt;
        logic [SHW-1:0] sh;
        int             bad = 0;
        for (int k = 0; k < 600; k++) begin
            op  = 2'($urandom_range(0, 3));
            opc = OPW'($urandom);
            alt = ($urandom_range(0, 1) != 0) ? OPW'($urandom_range(6, 7)) : OPW'($urandom);
            sh  = ($urandom_range(0, 7) == 0) ? SHW'($urandom) : SHW'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), op, opc, alt, sh, 1'($urandom_range(0, 3) != 0));
            checks++;
            if (obs() !== exp_vec) begin
                failures++;
                bad++;
                if (bad <= 8) $display("FAIL random cycle %0d: got %b required %b", k, obs(), exp_vec);
            end
            advance();
        end
        drain();
    endtask

    initial begin
        init_tables();
        illegal_m = 1'b0;
        exp_ir    = 1'b1;
        q.delete();
        test_reset();
        test_opcode_single();
        test_shift(1'b0);
        test_shift(1'b1);
        test_back_to_back();
        test_reset_mid_shift();
        test_max_shift();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, handshaked successor to the combinational ALU control decoder.
- Decodes ALUOp/Opcode/AlterOp into an ALU control code with parametrised widths.
- Sequences multi-bit shifts as repeated single-bit shift beats for the accumulator datapath's 1-bit shifter.
- Sits between the control unit (issue side) and the ALU/accumulator write-enable (datapath side).

Parameters:
- OPW, 5: width of Opcode and AlterOp; values are decoded on their low 5 bits, and any set upper bit decodes as unmapped.
- CTRLW, 4: width of Out; must be >= 4; bits above [3:0] are always 0.
- SHW, 4: width of ShAmt and of the internal beat counter.

Ports:
- CLK  in  1  clock, all logic on rising edge
- Reset_n  in  1  synchronous active-low reset
- ALUOp  in  2  00=add, 01=sub, 10=Opcode table, 11=AlterOp table
- Opcode  in  OPW  primary opcode
- AlterOp  in  OPW  alternate-op field
- ShAmt  in  SHW  shift count, used only when the decoded code is 0011 or 0100
- InValid  in  1  request valid
- InReady  out  1  request accepted when InValid && InReady
- Out  out  CTRLW  ALU control code for the current beat
- OutValid  out  1  beat valid
- OutReady  in  1  datapath consumes the beat when OutValid && OutReady
- Step  out  1  datapath write enable for this beat
- Last  out  1  final beat of the current request
- Busy  out  1  a multi-beat shift is in progress
- Illegal  out  1  sticky unmapped-code flag (optional feature only)

Behaviour:
- Reset (Reset_n=0 at a rising edge): state IDLE; Out=0; OutValid=0; Step=0; Last=0; Busy=0; Illegal=0; counter=0.
- Reset mid-shift aborts immediately; no further beats are issued.
- Opcode table (ALUOp=10): 00000→0000, 00001→0001, 00010→0111, 00011→0101, 00100→0110, 00101→0010, 01000→0101, 01001→0111, 01010→0110, 01011→0000, 01100→0010, 01101→0011, 01110→0100, 01111→1011, 10000→1000, 10001→1010, 10010→1011, 10011→1011, 10111→0000, 11000→1111, 11001→0000, 11101→1110. All other codes are unmapped and decode to 0000.
- AlterOp table (ALUOp=11): 00000→0000, 00001→0001, 00110→0011, 00111→0100, 01101→1100, 01110→1101. All other codes are unmapped and decode to 0000.
- Codes 0011 (SLL1) and 0100 (SRL1) are shift codes. Every other code is single-beat.
- States:
  - IDLE: InReady=1.
  - ISSUE: one beat held.
  - SHIFT: multi-beat.
- Accept, single-beat code: next cycle → ISSUE; Out=code; OutValid=1; Step=1; Last=1. Latency is exactly 1 cycle.
- Accept, shift code with ShAmt=N>0: next cycle → SHIFT; counter=N; Out=code; OutValid=1; Step=1; Busy=1; Last=(N==1).
- Each beat accepted in SHIFT decrements the counter and asserts Last on the beat where counter==1.
- Accepting the Last beat: → IDLE; OutValid=0; Busy=0.
- Accept, shift code with ShAmt=0: single ISSUE beat with Out=code, Step=0, Last=1, so the datapath holds its value.
- Beat stall: while OutValid && !OutReady, Out/Step/Last/counter are held unchanged.
- ISSUE back-to-back: InReady = OutReady. A request accepted in the same cycle the current beat is consumed is emitted next cycle with no bubble.
- SHIFT: InReady=0.
- Max ShAmt (2^SHW−1) yields exactly that many beats; the counter never wraps.
- Inputs are sampled only on the accept cycle; later changes have no effect on the request in flight.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_EN.
- Defined: an accepted request with an unmapped code sets Illegal on the next cycle; it stays set until reset. That request still issues one 0000 beat with Step=0.
- Undefined: Illegal is tied 0, and unmapped codes issue 0000 with Step=1.

Test Plan:
- Reset_n=0 for 2 cycles, then 1 → all outputs 0, InReady=1.
- ALUOp=10, Opcode=01111, OutReady=1 → one cycle later Out=1011, OutValid=1, Step=1, Last=1; then IDLE.
- ALUOp=11, AlterOp=00110, ShAmt=3, OutReady=1 → 3 beats of Out=0011 with Step=1, Last only on the 3rd, Busy=1 throughout, InReady=0.
- Same shift with OutReady low on the 2nd beat for 4 cycles → beat held with counter frozen; still exactly 3 beats total.
- Back-to-back ALUOp=00 then ALUOp=01 with OutReady=1 → Out=0000, then 0001 on consecutive cycles, no bubble.
- Reset_n=0 during beat 2 of ShAmt=15; also, with ALU_CTRL_ILLEGAL_EN, Opcode=00110 → outputs 0 next cycle; Illegal=1 and sticky, with a Step=0 beat.
